int_ctrl: RTL

Interrupt controller that sits between the external interrupt sources (timers, interrupt generator, external pins) and the CP0 `HWInt[5:0]` input. It synchronizes each source and applies per-source level or edge mode with pending latches and an enable mask. It exposes a small memory-mapped register file on the system bridge so the exception handler can configure it, identify the source and acknowledge it.

---
 rtl/int_ctrl_pkg.sv | 31 +++
 rtl/int_ctrl_if.sv | 12 +
 rtl/int_sync_edge.sv | 32 +++
 rtl/int_ctrl.sv | 107 ++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared constants for the interrupt controller and the bridge address decoder.
package int_ctrl_pkg;

  // Number of interrupt sources feeding CP0 HWInt.
  localparam int NSRC = 6;

  // Position of the valid flag in the ID register.
  localparam int ID_VALID_BIT = 31;

  // Byte offsets of the registers inside the block (Addr[1:0] always zero here).
  localparam logic [4:0] INT_EN   = 5'h00;
  localparam logic [4:0] INT_MODE = 5'h04;
  localparam logic [4:0] INT_PEND = 5'h08;
  localparam logic [4:0] INT_RAW  = 5'h0C;
  localparam logic [4:0] INT_ID   = 5'h10;

  // Lowest-index eligible source wins; the word is all zero when nothing is eligible.
  function automatic logic [31:0] id_word(input logic [NSRC-1:0] elig);
    logic [31:0] w;
    w = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        w = '0;
        w[ID_VALID_BIT] = 1'b1;
        w[2:0] = 3'(i);
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// System-bridge register port of the interrupt controller.
interface int_ctrl_if;
  logic [4:0]  Addr;
  logic        WE;
  logic [31:0] WData;
  logic [31:0] RData;

  // Bridge side drives address/strobe/data and samples read data.
  modport master (output Addr, output WE, output WData, input RData);
  // Controller side.
  modport slave  (input Addr, input WE, input WData, output RData);
endinterface

// File: rtl/int_sync_edge.sv
// Per-source synchronizer plus one extra flop for rising-edge detection.
module int_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic src_i,
  output logic s_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   p_q;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], src_i};

  // Synchronizer chain and previous-value flop, cleared by async reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      p_q    <= 1'b0;
    end else begin
      sync_q <= sync_d;
      p_q    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = s_o & ~p_q;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: per-source level/edge pending latches, enable mask,
// registered HWInt/IntAny to CP0 and a small memory-mapped register file.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] IntSrc,
  int_ctrl_if.slave       bus,
  output logic [NSRC-1:0] HWInt,
  output logic            IntAny
);

  logic [NSRC-1:0] s_w;
  logic [NSRC-1:0] rise_w;

  logic [NSRC-1:0] en_q,    en_d;
  logic [NSRC-1:0] mode_q,  mode_d;
  logic [NSRC-1:0] pend_q,  pend_d;
  logic [NSRC-1:0] hwint_q, hwint_d;
  logic            intany_q, intany_d;

  logic [4:0] reg_addr;
  logic       wr_en, wr_mode, wr_pend;
  logic       unused_bits;

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    int_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .reset  (reset),
      .src_i  (IntSrc[g]),
      .s_o    (s_w[g]),
      .rise_o (rise_w[g])
    );
  end

  // Byte offset with the ignored low bits forced to zero.
  assign reg_addr    = {bus.Addr[4:2], 2'b00};
  assign wr_en       = bus.WE && (reg_addr == INT_EN);
  assign wr_mode     = bus.WE && (reg_addr == INT_MODE);
  assign wr_pend     = bus.WE && (reg_addr == INT_PEND);
  assign unused_bits = ^{bus.WData[31:NSRC], bus.Addr[1:0]};

  // Next-state for the configuration registers.
  always_comb begin
    en_d   = wr_en   ? bus.WData[NSRC-1:0] : en_q;
    mode_d = wr_mode ? bus.WData[NSRC-1:0] : mode_q;
  end

  // Pending update: the mode in force during this cycle decides the rule,
  // so an edge->level switch only starts following s on the next cycle.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NSRC; i++) begin
      if (!mode_q[i]) begin
        // Level source; switching it to edge starts from a clean slate.
        if (wr_mode && bus.WData[i]) pend_d[i] = 1'b0;
        else                         pend_d[i] = s_w[i];
      end else begin
        // Edge source: a new rise beats a simultaneous W1C.
        pend_d[i] = rise_w[i] | (pend_q[i] & ~(wr_pend & bus.WData[i]));
      end
    end
  end

  // CP0 outputs are registered from the post-update pending and enable state.
  always_comb begin
    hwint_d  = pend_d & en_d;
    intany_d = |hwint_d;
  end

  // All controller state, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q     <= '0;
      mode_q   <= '0;
      pend_q   <= '0;
      hwint_q  <= '0;
      intany_q <= 1'b0;
    end else begin
      en_q     <= en_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
      hwint_q  <= hwint_d;
      intany_q <= intany_d;
    end
  end

  assign HWInt  = hwint_q;
  assign IntAny = intany_q;

  // Combinational read mux over current register state.
  always_comb begin
    bus.RData = '0;
    case (reg_addr)
      INT_EN:   bus.RData[NSRC-1:0] = en_q;
      INT_MODE: bus.RData[NSRC-1:0] = mode_q;
      INT_PEND: bus.RData[NSRC-1:0] = pend_q;
      INT_RAW:  bus.RData[NSRC-1:0] = s_w;
      INT_ID:   bus.RData = id_word(pend_q & en_q);
      default:  bus.RData = '0;
    endcase
  end

endmodule
